ysyx_22041412_ifq: RTL and testbench

Instruction fetch queue between the IFU and the ID stage. It buffers fetched {pc, instruction} pairs in a small circular FIFO so that ID stalls do not back-pressure the I-cache line stream. Each entry is tagged with a one-bit predecode flag marking control-transfer instructions. A single-cycle flush discards all entries when a redirect target arrives from MEM.

---
 rtl/ysyx_22041412_pkg.sv | 25 ++
 rtl/ysyx_22041412_ifq_if.sv | 34 +++
 rtl/ysyx_22041412_predecode.sv | 23 ++
 rtl/ysyx_22041412_ifq.sv | 107 ++++++++++
 tb/tb_ysyx_22041412_ifq.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041412_pkg.sv
// Shared constants and types for the fetch-queue slice.
// Holds the RV64 opcode / funct12 values used by predecode and the
// packed {inst, ctrl} payload stored per queue entry.
package ysyx_22041412_pkg;

  localparam int unsigned INST_W = 32;

  // Major opcodes (inst[6:0]) of control-transfer instructions
  localparam logic [6:0] JAL         = 7'b1101111;
  localparam logic [6:0] JALR        = 7'b1100111;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] ENVIRONMENT = 7'b1110011;

  // funct12 (inst[31:20]) values within the ENVIRONMENT opcode
  localparam logic [11:0] ECALL = 12'h000;
  localparam logic [11:0] MRET  = 12'h302;

  // Per-entry instruction payload; PC is kept in its own array since its
  // width is a module parameter.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic              ctrl;
  } ifq_ent_t;

endpackage

// File: rtl/ysyx_22041412_ifq_if.sv
// Handshake bundle between IFU, the fetch queue and ID.
// slave  : queue view (consumes in_*, out_ready, flush; drives the rest)
// master : environment view (mirror of slave)
// Signals: in_valid/in_ready/in_pc/in_inst, out_valid/out_ready/out_pc/
//          out_inst/out_ctrl, flush, count (occupancy).
interface ysyx_22041412_ifq_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 64
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [31:0]      out_inst;
  logic             out_ctrl;
  logic             flush;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst, out_ctrl, count
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst, out_ctrl, count
  );

endinterface

// File: rtl/ysyx_22041412_predecode.sv
// Combinational predecode: flags jal/jalr/branch/ecall/mret.
// Ports: inst (32-bit instruction word) -> ctrl (1 = control transfer).
module ysyx_22041412_predecode
  import ysyx_22041412_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic              ctrl
);

  // Bits between funct12 and the opcode do not affect the decision
  logic unused_inst;
  assign unused_inst = ^inst[19:7];

  always_comb begin
    ctrl = 1'b0;
    case (inst[6:0])
      JAL, JALR, B_TYPE: ctrl = 1'b1;
      ENVIRONMENT:       ctrl = (inst[31:20] == ECALL) || (inst[31:20] == MRET);
      default:           ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_ifq.sv
// Instruction fetch queue: circular FIFO of {pc, inst, ctrl} between IFU
// and ID, with single-cycle flush on redirect.
// Ports: clk, rst_n (async active-low), bus (ysyx_22041412_ifq_if.slave).
// Optional: YSYX_22041412_IFQ_BYPASS_EN lets an instruction arriving at an
// empty queue appear on out_* in the same cycle.
module ysyx_22041412_ifq
  import ysyx_22041412_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ysyx_22041412_ifq_if.slave      bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   count_q,  count_d;
  logic [PC_W-1:0] pc_mem_q  [DEPTH];
  logic [PC_W-1:0] pc_mem_d  [DEPTH];
  ifq_ent_t        ent_mem_q [DEPTH];
  ifq_ent_t        ent_mem_d [DEPTH];

  logic            in_ctrl;
  logic            empty, full;
  logic            in_ready_c, out_valid_c;
  logic            enq, deq, wr_en, byp, pass;
  logic [AW-1:0]   rd_idx, wr_idx;

  ysyx_22041412_predecode u_predecode (
    .inst (bus.in_inst),
    .ctrl (in_ctrl)
  );

  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign empty  = (rd_ptr_q == wr_ptr_q);
  assign full   = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

`ifdef YSYX_22041412_IFQ_BYPASS_EN
  // Empty queue forwards the incoming instruction straight to ID
  assign byp  = empty & bus.in_valid & ~bus.flush;
`else
  assign byp  = 1'b0;
`endif
  assign pass = byp & bus.out_ready;

  assign in_ready_c  = ~full & ~bus.flush;
  assign out_valid_c = (~empty | byp) & ~bus.flush;
  assign enq         = bus.in_valid & in_ready_c;
  assign deq         = out_valid_c & bus.out_ready & ~empty;
  // A passed-through instruction is consumed without touching storage
  assign wr_en       = enq & ~pass;

  // Pointer, occupancy and storage next-state
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    pc_mem_d  = pc_mem_q;
    ent_mem_d = ent_mem_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d          = wr_ptr_q + PW'(1);
        pc_mem_d[wr_idx]  = bus.in_pc;
        ent_mem_d[wr_idx] = '{inst: bus.in_inst, ctrl: in_ctrl};
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]  <= '0;
        ent_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pc_mem_q  <= pc_mem_d;
      ent_mem_q <= ent_mem_d;
    end
  end

  // Output side: head register, or the live input while bypassing
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_pc    = byp ? bus.in_pc   : pc_mem_q[rd_idx];
  assign bus.out_inst  = byp ? bus.in_inst : ent_mem_q[rd_idx].inst;
  assign bus.out_ctrl  = byp ? in_ctrl     : ent_mem_q[rd_idx].ctrl;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_ysyx_22041412_ifq.sv
// Directed bench for ysyx_22041412_ifq with a queue-based reference model.
module tb_ysyx_22041412_ifq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_22041412_ifq_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  ysyx_22041412_ifq #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic ref_ctrl(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    if (op == 7'h6F || op == 7'h67 || op == 7'h63) return 1'b1;
    if (op == 7'h73) return (i[31:20] == 12'h000) || (i[31:20] == 12'h302);
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, compare combinational/registered outputs
  // against the model, then advance the model as the next edge will.
  task automatic step(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl);
    logic exp_rdy, exp_ov, byp;
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    exp_rdy = (sb.size() < int'(DEPTH)) && !fl;
    exp_ov  = (sb.size() > 0) && !fl;
    byp     = 1'b0;
`ifdef YSYX_22041412_IFQ_BYPASS_EN
    if (sb.size() == 0 && iv && !fl) begin
      exp_ov = 1'b1;
      byp    = 1'b1;
    end
`endif
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    check("count", 64'(bus.count), 64'(sb.size()));
    if (exp_ov) begin
      if (byp) e = '{pc: pc, inst: inst, ctrl: ref_ctrl(inst)};
      else     e = sb[0];
      check("out_pc", bus.out_pc, e.pc);
      check("out_inst", 64'(bus.out_inst), 64'(e.inst));
      check("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (exp_ov && ordy && !byp) void'(sb.pop_front());
      if (iv && exp_rdy && !(byp && ordy))
        sb.push_back('{pc: pc, inst: inst, ctrl: ref_ctrl(inst)});
    end
  endtask

  task automatic idle();
    step(1'b0, 64'h0, NOP, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] pd [6];
    logic [63:0] pc;
    pd[0] = 32'h0000_006F; pd[1] = 32'h0000_8067; pd[2] = 32'h0000_0063;
    pd[3] = 32'h0000_0073; pd[4] = 32'h3020_0073; pd[5] = 32'h0000_0013;

    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_pc", bus.out_pc, 64'd0);
    check("rst_out_inst", 64'(bus.out_inst), 64'd0);
    check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    rst_n = 1'b1;

    // Fill to full with ID stalled, one more attempt refused, then drain
    for (int i = 0; i < 4; i++) step(1'b1, 64'h8000_0000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0010, NOP, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0014, NOP, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, NOP, 1'b1, 1'b0);
    idle();

    // Predecode patterns
    for (int i = 0; i < 4; i++) step(1'b1, 64'h9000_0000 + 64'(4 * i), pd[i], 1'b0, 1'b0);
    for (int i = 4; i < 6; i++) step(1'b1, 64'h9000_0000 + 64'(4 * i), pd[i], 1'b1, 1'b0);
    step(1'b1, 64'h9000_0018, 32'h0010_0073, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 64'h0, NOP, 1'b1, 1'b0);

    // Flush with three queued entries and a concurrent push
    for (int i = 0; i < 3; i++) step(1'b1, 64'hA000_0000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    step(1'b1, 64'hA000_000C, NOP, 1'b1, 1'b1);
    idle();
    idle();

    // Steady stream at occupancy 1
    step(1'b1, 64'hB000_0000, NOP, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b1, 64'hB000_0000 + 64'(4 * i), NOP, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 64'h0, NOP, 1'b1, 1'b0);

    // Pointer wrap with interleaved stalls on both sides
    pc = 64'hC000_0000;
    for (int i = 0; i < 16; i++) begin
      step(1'b1 ^ (i % 3 == 2), pc, pd[i % 6], 1'b1 ^ (i % 4 == 1), 1'b0);
      pc += 64'd4;
    end
    for (int i = 0; i < 5; i++) step(1'b0, 64'h0, NOP, 1'b1, 1'b0);

    // Empty-queue arrival with ID ready (same-cycle pass when bypass is built)
    step(1'b1, 64'h8000_0010, NOP, 1'b1, 1'b0);
    step(1'b0, 64'h0, NOP, 1'b1, 1'b0);
    idle();

    // Reset during operation clears everything at once
    for (int i = 0; i < 2; i++) step(1'b1, 64'hD000_0000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(bus.count), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_pc", bus.out_pc, 64'd0);
    sb.delete();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step(1'b1, 64'hE000_0000, 32'h0000_0063, 1'b0, 1'b0);
    step(1'b0, 64'h0, NOP, 1'b1, 1'b0);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
